lcd_text_source: RTL

Upstream pixel source for the 128x64 two-controller graphic LCD writer. It holds a 16-cell character buffer written by host logic. On request it returns one 8-bit page column byte from an 8x16 font (upper page = glyph rows 0-7, lower page = rows 8-15). It applies a horizontal scroll offset so the writer can stream columns 0..127 without knowing the text content.

---
 rtl/lcd_text_source_if.sv | 28 ++
 rtl/lcd_text_source.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lcd_text_source_if.sv
// Bundle of host-write, scroll and column-request signals between the
// LCD writer / host logic (master) and the text source (slave).
interface lcd_text_source_if;
  logic       WR_EN;
  logic [3:0] WR_ADDR;
  logic [7:0] WR_CHAR;
  logic       SCROLL_EN;
  logic       SCROLL_TICK;
  logic       REQ;
  logic [6:0] REQ_COL;
  logic       REQ_HALF;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       BUSY;
  logic [6:0] SCROLL_OFS;

  modport master (
    output WR_EN, WR_ADDR, WR_CHAR, SCROLL_EN, SCROLL_TICK,
           REQ, REQ_COL, REQ_HALF,
    input  DATA, DATA_VALID, BUSY, SCROLL_OFS
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_CHAR, SCROLL_EN, SCROLL_TICK,
           REQ, REQ_COL, REQ_HALF,
    output DATA, DATA_VALID, BUSY, SCROLL_OFS
  );
endinterface

// File: rtl/lcd_text_source.sv
// Text-mode pixel source for the 128x64 graphic LCD writer.
// Holds a 16-cell character buffer, applies a horizontal scroll offset and
// returns one 8-bit page column byte from an 8x16 font, two cycles after an
// accepted request.
module lcd_text_source #(
  parameter int unsigned SCROLL_STEP = 1,
  parameter logic [7:0]  INIT_CHAR   = 8'h20
) (
  input logic          CLK,
  input logic          RESET,
  lcd_text_source_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOOKUP, OUTPUT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cell_q [16];
  logic [6:0]  scroll_ofs_q;
  logic [6:0]  eff_q;
  logic        half_q;
  logic [7:0]  char_q;
  logic [2:0]  gcol_q;
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic        accept;

  // Glyph columns 0..7, each 9 bits covering rows 3..11 (bit0 = row 3).
  function automatic logic [71:0] glyph(input logic [7:0] code);
    logic [71:0] g;
    g = '0;
    case (code)
      8'h21: g = {9'h000, 9'h000, 9'h000, 9'h01F, 9'h19F, 9'h180, 9'h000, 9'h000};
      8'h30: g = {9'h1FF, 9'h101, 9'h101, 9'h101, 9'h1FF, 27'h0};
      8'h31: g = {9'h000, 9'h002, 9'h1FF, 9'h000, 9'h000, 27'h0};
      8'h32: g = {9'h1F1, 9'h111, 9'h111, 9'h111, 9'h11F, 27'h0};
      8'h33: g = {9'h111, 9'h111, 9'h111, 9'h111, 9'h1FF, 27'h0};
      8'h34: g = {9'h01F, 9'h010, 9'h010, 9'h010, 9'h1FF, 27'h0};
      8'h35: g = {9'h11F, 9'h111, 9'h111, 9'h111, 9'h1F1, 27'h0};
      8'h36: g = {9'h1FF, 9'h111, 9'h111, 9'h111, 9'h1F1, 27'h0};
      8'h37: g = {9'h001, 9'h001, 9'h001, 9'h001, 9'h1FF, 27'h0};
      8'h38: g = {9'h1FF, 9'h111, 9'h111, 9'h111, 9'h1FF, 27'h0};
      8'h39: g = {9'h11F, 9'h111, 9'h111, 9'h111, 9'h1FF, 27'h0};
      8'h41: g = {9'h1FF, 9'h011, 9'h011, 9'h011, 9'h1FF, 27'h0};
      8'h42: g = {9'h1FF, 9'h111, 9'h111, 9'h111, 9'h1EE, 27'h0};
      8'h43: g = {9'h1FF, 9'h101, 9'h101, 9'h101, 9'h101, 27'h0};
      8'h44: g = {9'h1FF, 9'h101, 9'h101, 9'h101, 9'h0FE, 27'h0};
      8'h45: g = {9'h1FF, 9'h111, 9'h111, 9'h111, 9'h101, 27'h0};
      8'h46: g = {9'h1FF, 9'h011, 9'h011, 9'h011, 9'h001, 27'h0};
      8'h47: g = {9'h1FF, 9'h101, 9'h101, 9'h111, 9'h1F1, 27'h0};
      8'h48: g = {9'h1FF, 9'h1FF, 9'h111, 9'h010, 9'h010, 9'h111, 9'h1FF, 9'h1FF};
      8'h49: g = {9'h101, 9'h101, 9'h1FF, 9'h101, 9'h101, 27'h0};
      8'h4A: g = {9'h180, 9'h100, 9'h100, 9'h100, 9'h1FF, 27'h0};
      8'h4B: g = {9'h1FF, 9'h010, 9'h028, 9'h044, 9'h183, 27'h0};
      8'h4C: g = {9'h1FF, 9'h100, 9'h100, 9'h100, 9'h100, 27'h0};
      8'h4D: g = {9'h1FF, 9'h002, 9'h004, 9'h002, 9'h1FF, 27'h0};
      8'h4E: g = {9'h1FF, 9'h004, 9'h010, 9'h040, 9'h1FF, 27'h0};
      8'h4F: g = {9'h1FF, 9'h101, 9'h101, 9'h101, 9'h1FF, 27'h0};
      8'h50: g = {9'h1FF, 9'h011, 9'h011, 9'h011, 9'h01F, 27'h0};
      8'h51: g = {9'h1FF, 9'h101, 9'h101, 9'h181, 9'h1FF, 27'h0};
      8'h52: g = {9'h1FF, 9'h011, 9'h031, 9'h051, 9'h19F, 27'h0};
      8'h53: g = {9'h11F, 9'h111, 9'h111, 9'h111, 9'h1F1, 27'h0};
      8'h54: g = {9'h001, 9'h001, 9'h1FF, 9'h001, 9'h001, 27'h0};
      8'h55: g = {9'h1FF, 9'h100, 9'h100, 9'h100, 9'h1FF, 27'h0};
      8'h56: g = {9'h03F, 9'h0C0, 9'h100, 9'h0C0, 9'h03F, 27'h0};
      8'h57: g = {9'h1FF, 9'h080, 9'h040, 9'h080, 9'h1FF, 27'h0};
      8'h58: g = {9'h183, 9'h044, 9'h038, 9'h044, 9'h183, 27'h0};
      8'h59: g = {9'h003, 9'h00C, 9'h1F0, 9'h00C, 9'h003, 27'h0};
      8'h5A: g = {9'h181, 9'h141, 9'h111, 9'h105, 9'h103, 27'h0};
      default: g = '0;  // space and every unsupported code render blank
    endcase
    return g;
  endfunction

  // Upper page carries rows 3..7 in bits 3..7; lower page rows 8..11 in bits 0..3.
  function automatic logic [7:0] font_byte(input logic [7:0] code,
                                           input logic [2:0] gcol,
                                           input logic       half);
    logic [8:0] p;
    p = 9'(glyph(code) >> (9 * (7 - int'(gcol))));
    return half ? {4'b0000, p[8:5]} : {p[4:0], 3'b000};
  endfunction

  assign accept = (state_q == IDLE) && bus.REQ;

  // Request FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request FSM next-state: a fixed three-step walk once a request is taken.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.REQ) state_d = LOOKUP;
      LOOKUP:  state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Character buffer: one host write per cycle, every cell preset at reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: the buffer is flops, not RAM, so it can and must take a reset value.
      for (int i = 0; i < 16; i++) cell_q[i] <= INIT_CHAR;
    end else if (bus.WR_EN) begin
      // NOTE: non-blocking, so a same-edge lookup still reads the old char.
      cell_q[bus.WR_ADDR] <= bus.WR_CHAR;
    end
  end

  // Scroll offset advances on enabled ticks and wraps modulo 128.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                             scroll_ofs_q <= '0;
    else if (bus.SCROLL_EN && bus.SCROLL_TICK) scroll_ofs_q <= scroll_ofs_q + 7'(SCROLL_STEP);
  end

  // Request datapath: latch scrolled column, fetch char, then emit the font byte.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      eff_q        <= '0;
      half_q       <= 1'b0;
      char_q       <= '0;
      gcol_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (accept) begin
        eff_q  <= bus.REQ_COL + scroll_ofs_q;
        half_q <= bus.REQ_HALF;
      end
      if (state_q == LOOKUP) begin
        char_q <= cell_q[eff_q[6:3]];
        gcol_q <= eff_q[2:0];
      end
      if (state_q == OUTPUT) begin
        data_q       <= font_byte(char_q, gcol_q, half_q);
        data_valid_q <= 1'b1;
      end
    end
  end

  assign bus.DATA       = data_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.BUSY       = (state_q != IDLE);
  assign bus.SCROLL_OFS = scroll_ofs_q;

endmodule
